shift_rows_stream: RTL and testbench

- Column-serial, double-buffered ShiftRows / InvShiftRows engine for the iterative AES datapath.
- Accepts one 32-bit state column per beat and buffers a full NB-column state. Emits the row-shifted state one column per beat.
- Generalised to Rijndael block widths (NB = 4/6/8) with a per-block forward/inverse mode.
- Sits between the SubBytes and MixColumns column streams; ping-pong banks give a sustained 1 column/cycle.

---
 rtl/shift_rows_stream.sv | 197 +++++++++++++++++++
 tb/tb_shift_rows_stream.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_stream.sv
// rtl/shift_rows_stream.sv - column-serial ping-pong ShiftRows/InvShiftRows engine for NB = 4/6/8
// Optional macro SHIFTROW_PARITY_EN adds per-byte even parity (in_par, out_par, sticky par_err).
module shift_rows_stream #(
    parameter int NB = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_col,
    input  logic        in_inv,
`ifdef SHIFTROW_PARITY_EN
    input  logic [3:0]  in_par,
    output logic [3:0]  out_par,
    output logic        par_err,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_col,
    output logic        out_last,
    output logic        out_inv
);

    localparam int            IW       = $clog2(NB);
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    generate
        if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
            $error("shift_rows_stream: NB must be 4, 6 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } bank_state_t;

    bank_state_t   bank_st     [2];
    bank_state_t   bank_st_nxt [2];
    logic [31:0]   mem         [2][NB];
    logic [1:0]    mode;
    logic          wr_bank;
    logic          rd_bank;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          in_fire;
    logic          out_fire;
    logic [31:0]   shifted;

    // Rijndael row offsets: the wide block shifts rows 2 and 3 one extra place.
    function automatic int row_off(input int r);
        return (NB == 8 && r >= 2) ? r + 1 : r;
    endfunction

    // Bank state register
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
        end else begin
            bank_st[0] <= bank_st_nxt[0];
            bank_st[1] <= bank_st_nxt[1];
        end
    end

    // Bank next state; fill and drain never target the same bank in one cycle.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_st_nxt[b] = bank_st[b];
            if (in_fire && (wr_bank == 1'(b))) begin
                if (wr_idx == LAST_IDX) begin
                    bank_st_nxt[b] = FULL;
                end else begin
                    bank_st_nxt[b] = FILL;
                end
            end
            if (out_fire && (rd_bank == 1'(b)) && (rd_idx == LAST_IDX)) begin
                bank_st_nxt[b] = EMPTY;
            end
        end
    end

    // Outputs are decoded from registered bank state only.
    always_comb begin
        in_ready  = (bank_st[wr_bank] != FULL);
        out_valid = (bank_st[rd_bank] == FULL);
        out_last  = out_valid && (rd_idx == LAST_IDX);
        out_inv   = out_valid && mode[rd_bank];
        out_col   = out_valid ? shifted : 32'h0;
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
            rd_bank <= 1'b0;
            rd_idx  <= '0;
            mode    <= 2'b00;
        end else begin
            if (in_fire) begin
                if (wr_idx == '0) begin
                    mode[wr_bank] <= in_inv;
                end
                if (wr_idx == LAST_IDX) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            if (out_fire) begin
                if (rd_idx == LAST_IDX) begin
                    rd_idx  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end
        end
    end

    // Column storage needs no reset: bank state gates everything read out of it.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wr_bank][wr_idx] <= in_col;
        end
    end

    always_comb begin
        shifted = 32'h0;
        for (int c = 0; c < NB; c++) begin
            if (rd_idx == IW'(c)) begin
                for (int r = 0; r < 4; r++) begin
                    if (mode[rd_bank]) begin
                        shifted[31-8*r -: 8] =
                            mem[rd_bank][IW'((c - row_off(r) + NB) % NB)][31-8*r -: 8];
                    end else begin
                        shifted[31-8*r -: 8] =
                            mem[rd_bank][IW'((c + row_off(r)) % NB)][31-8*r -: 8];
                    end
                end
            end
        end
    end

`ifdef SHIFTROW_PARITY_EN
    logic [3:0] par_mem [2][NB];
    logic [3:0] calc_par;
    logic [3:0] shifted_par;

    always_comb begin
        calc_par = 4'h0;
        for (int r = 0; r < 4; r++) begin
            calc_par[3-r] = ^in_col[31-8*r -: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            par_mem[wr_bank][wr_idx] <= in_par;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (in_fire && (calc_par != in_par)) begin
            par_err <= 1'b1;
        end
    end

    // Parity bits travel with their bytes through the same permutation.
    always_comb begin
        shifted_par = 4'h0;
        for (int c = 0; c < NB; c++) begin
            if (rd_idx == IW'(c)) begin
                for (int r = 0; r < 4; r++) begin
                    if (mode[rd_bank]) begin
                        shifted_par[3-r] =
                            par_mem[rd_bank][IW'((c - row_off(r) + NB) % NB)][3-r];
                    end else begin
                        shifted_par[3-r] =
                            par_mem[rd_bank][IW'((c + row_off(r)) % NB)][3-r];
                    end
                end
            end
        end
    end

    assign out_par = out_valid ? shifted_par : 4'h0;
`endif

endmodule

// File: tb/tb_shift_rows_stream.sv
// tb/tb_shift_rows_stream.sv - directed-vector bench for shift_rows_stream (NB=4 and NB=8 instances)
module tb_shift_rows_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, in_inv;
    logic        out_valid, out_ready, out_last, out_inv;
    logic [31:0] in_col, out_col;
    logic        in8_valid, in8_ready, in8_inv;
    logic        out8_valid, out8_ready, out8_last, out8_inv;
    logic [31:0] in8_col, out8_col;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] vec_a [4] = '{32'h63C0AB20, 32'hEB2F30CB, 32'h9F93AF2B, 32'hA092C7A2};
    logic [31:0] vec_b [4] = '{32'h632FAFA2, 32'hEB93C720, 32'h9F92ABCB, 32'hA0C0302B};
    logic [31:0] vec_c [4] = '{32'h6393AB2B, 32'hEB9230A2, 32'h9FC0AF20, 32'hA02FC7CB};
    logic [31:0] exp8  [8] = '{32'h00112334, 32'h01122435, 32'h02132536, 32'h03142637,
                               32'h04152730, 32'h05162031, 32'h06172132, 32'h07102233};

`ifdef SHIFTROW_PARITY_EN
    logic [3:0] par_flip, in_par, out_par, in8_par, out8_par;
    logic       par_err, par8_err;

    function automatic logic [3:0] byte_par(input logic [31:0] w);
        logic [3:0] p;
        for (int r = 0; r < 4; r++) p[3-r] = ^w[31-8*r -: 8];
        return p;
    endfunction

    assign in_par  = byte_par(in_col) ^ par_flip;
    assign in8_par = byte_par(in8_col);
`endif

    shift_rows_stream #(.NB(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col), .in_inv(in_inv),
`ifdef SHIFTROW_PARITY_EN
        .in_par(in_par), .out_par(out_par), .par_err(par_err),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
        .out_last(out_last), .out_inv(out_inv)
    );

    shift_rows_stream #(.NB(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in8_valid), .in_ready(in8_ready), .in_col(in8_col), .in_inv(in8_inv),
`ifdef SHIFTROW_PARITY_EN
        .in_par(in8_par), .out_par(out8_par), .par_err(par8_err),
`endif
        .out_valid(out8_valid), .out_ready(out8_ready), .out_col(out8_col),
        .out_last(out8_last), .out_inv(out8_inv)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            out_inv !== 1'b0 || out_col !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_last=%b out_inv=%b out_col=%h, want 1 0 0 0 00000000",
                     in_ready, out_valid, out_last, out_inv, out_col);
        end
        vectors++;
        if (in8_ready !== 1'b1 || out8_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_nb8: in_ready=%b out_valid=%b, want 1 0", in8_ready, out8_valid);
        end
    endtask

    task automatic test_forward();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_col = vec_a[i]; in_inv = 1'b0;
            vectors++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL fwd_in%0d: in_ready=%b out_valid=%b, want 1 0", i, in_ready, out_valid);
            end
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_col !== vec_b[i] || out_last !== (i == 3) || out_inv !== 1'b0) begin
                miscompares++;
                $display("FAIL fwd_out%0d: valid=%b col=%h last=%b inv=%b, want 1 %h %b 0",
                         i, out_valid, out_col, out_last, out_inv, vec_b[i], (i == 3));
            end
            step();
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fwd_idle: out_valid=%b, want 0", out_valid);
        end
    endtask

    // in_inv only high on the first column: the block's stored mode must govern all four.
    task automatic test_inverse();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_col = vec_b[i]; in_inv = (i == 0);
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_col !== vec_a[i] || out_last !== (i == 3) || out_inv !== 1'b1) begin
                miscompares++;
                $display("FAIL inv_out%0d: valid=%b col=%h last=%b inv=%b, want 1 %h %b 1",
                         i, out_valid, out_col, out_last, out_inv, vec_a[i], (i == 3));
            end
            step();
        end
    endtask

    task automatic test_nb8();
        out8_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in8_valid = 1'b1; in8_inv = 1'b0;
            in8_col = {8'(c), 8'(16 + c), 8'(32 + c), 8'(48 + c)};
            vectors++;
            if (in8_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL nb8_in%0d: in_ready=%b, want 1", c, in8_ready);
            end
            step();
        end
        in8_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            vectors++;
            if (out8_valid !== 1'b1 || out8_col !== exp8[c] || out8_last !== (c == 7)) begin
                miscompares++;
                $display("FAIL nb8_out%0d: valid=%b col=%h last=%b, want 1 %h %b",
                         c, out8_valid, out8_col, out8_last, exp8[c], (c == 7));
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] bp_in  [12];
        logic [31:0] bp_exp [12];
        logic        bp_mode [3] = '{1'b0, 1'b1, 1'b0};
        int          nin, nout, cyc, k;
        logic        acc;
        for (int i = 0; i < 4; i++) begin
            bp_in[i] = vec_a[i]; bp_in[4+i] = vec_b[i]; bp_in[8+i] = vec_b[i];
            bp_exp[i] = vec_b[i]; bp_exp[4+i] = vec_a[i]; bp_exp[8+i] = vec_c[i];
        end
        out_ready = 1'b0;
        nin = 0;
        for (int s = 0; s < 12; s++) begin
            in_valid = 1'b1; in_col = bp_in[nin]; in_inv = bp_mode[nin/4];
            acc = in_ready;
            step();
            if (acc) nin++;
        end
        vectors++;
        if (nin != 8 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_fill: accepts=%0d in_ready=%b, want 8 0", nin, in_ready);
        end
        for (int s = 0; s < 3; s++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_col !== vec_b[0] || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_stall%0d: valid=%b col=%h in_ready=%b, want 1 %h 0",
                         s, out_valid, out_col, in_ready, vec_b[0]);
            end
            step();
        end
        out_ready = 1'b1;
        nout = 0;
        cyc = 0;
        while (nout < 12 && cyc < 100) begin
            k = (nin < 12) ? nin : 11;
            in_valid = (nin < 12); in_col = bp_in[k]; in_inv = bp_mode[k/4];
            acc = in_valid && in_ready;
            if (out_valid === 1'b1) begin
                vectors++;
                if (out_col !== bp_exp[nout] || out_last !== (nout % 4 == 3) || out_inv !== bp_mode[nout/4]) begin
                    miscompares++;
                    $display("FAIL bp_out%0d: col=%h last=%b inv=%b, want %h %b %b",
                             nout, out_col, out_last, out_inv, bp_exp[nout], (nout % 4 == 3), bp_mode[nout/4]);
                end
                nout++;
            end
            step();
            if (acc) nin++;
            cyc++;
        end
        in_valid = 1'b0;
        vectors++;
        if (nout != 12 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain: outputs=%0d out_valid=%b, want 12 0", nout, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_col = vec_a[i % 4]; in_inv = 1'b0;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rstmid_idle%0d: out_valid=%b, want 0", s, out_valid);
            end
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_col = vec_b[i]; in_inv = 1'b1;
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_col !== vec_a[i] || out_last !== (i == 3) || out_inv !== 1'b1) begin
                miscompares++;
                $display("FAIL rstmid_out%0d: valid=%b col=%h last=%b inv=%b, want 1 %h %b 1",
                         i, out_valid, out_col, out_last, out_inv, vec_a[i], (i == 3));
            end
            step();
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_end: out_valid=%b, want 0", out_valid);
        end
    endtask

`ifdef SHIFTROW_PARITY_EN
    task automatic test_parity();
        out_ready = 1'b1;
        par_flip  = 4'h0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_col = vec_a[i]; in_inv = 1'b0;
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_par !== byte_par(vec_b[i]) || par_err !== 1'b0) begin
                miscompares++;
                $display("FAIL par_out%0d: valid=%b par=%b err=%b, want 1 %b 0",
                         i, out_valid, out_par, par_err, byte_par(vec_b[i]));
            end
            step();
        end
        in_valid = 1'b1; in_col = vec_a[0]; par_flip = 4'b0100;
        step();
        in_valid = 1'b0; par_flip = 4'h0;
        for (int s = 0; s < 3; s++) begin
            vectors++;
            if (par_err !== 1'b1) begin
                miscompares++;
                $display("FAIL par_err%0d: par_err=%b, want 1", s, par_err);
            end
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (par_err !== 1'b0) begin
            miscompares++;
            $display("FAIL par_clear: par_err=%b, want 0", par_err);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_col = 32'h0; in_inv = 1'b0; out_ready = 1'b0;
        in8_valid = 1'b0; in8_col = 32'h0; in8_inv = 1'b0; out8_ready = 1'b0;
`ifdef SHIFTROW_PARITY_EN
        par_flip = 4'h0;
`endif
        test_reset();
        test_forward();
        test_inverse();
        test_nb8();
        test_backpressure();
        test_reset_mid();
`ifdef SHIFTROW_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
